// File: rtl/iter_alu_if.sv
// iter_alu_if: start/busy/done handshake and operand/result bus of the iterative ALU
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluCtr;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] aluRes;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, aluCtr, input1, input2,
        input  busy, done, aluRes, zero, hi, lo
    );

    modport slave (
        input  start, aluCtr, input1, input2,
        output busy, done, aluRes, zero, hi, lo
    );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: registered single-cycle ALU ops plus iterative unsigned multiply/divide into HI/LO
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic   clk,
    input logic   reset,
    iter_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, quo, opb, res, hi_r, lo_r, sc_res, step_acc, step_quo;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             done_r, zero_r, is_mul, is_div, last;

    assign is_mul = bus.start && bus.aluCtr == 4'b1001;
    assign is_div = bus.start && bus.aluCtr == 4'b1010 && bus.input2 != '0;
    assign last   = cnt == CNT_W'(1);

    assign bus.done   = done_r;
    assign bus.aluRes = res;
    assign bus.zero   = zero_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;

    // Single-cycle result; DIVU only lands here when dividing by zero, giving all-ones
    always_comb begin
        case (bus.aluCtr)
            4'b0000: sc_res = bus.input1 & bus.input2;
            4'b0001: sc_res = bus.input1 | bus.input2;
            4'b0011: sc_res = bus.input1 ^ bus.input2;
            4'b1100: sc_res = ~(bus.input1 | bus.input2);
            4'b0010: sc_res = bus.input1 + bus.input2;
            4'b0110: sc_res = bus.input1 - bus.input2;
            4'b0111: sc_res = WIDTH'($signed(bus.input1) < $signed(bus.input2));
            4'b1000: sc_res = WIDTH'(bus.input1 < bus.input2);
            4'b1010: sc_res = '1;
            default: sc_res = '0;
        endcase
    end

    // One shift-add (MUL) or shift-subtract-restore (DIV) step; acc is hi/remainder, quo is lo/quotient
    always_comb begin
        mul_sum  = {1'b0, acc} + (quo[0] ? {1'b0, opb} : '0);
        div_sh   = {acc, quo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        step_acc = state == MUL ? mul_sum[WIDTH:1] : div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        step_quo = state == MUL ? {mul_sum[0], quo[WIDTH-1:1]} : {quo[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: leave IDLE only for multi-cycle ops, return on the last iteration
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = is_mul ? MUL : is_div ? DIV : IDLE;
            default: next_state = last ? IDLE : state;
        endcase
    end

    // Busy whenever an iteration is pending
    always_comb begin
        bus.busy = state != IDLE;
    end

    // Datapath: latch operands, iterate, and publish results with a one-cycle done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            quo    <= '0;
            opb    <= '0;
            res    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            zero_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (is_mul || is_div) begin
                    acc <= '0;
                    quo <= bus.input1;
                    opb <= bus.input2;
                    cnt <= CNT_W'(WIDTH);
                end else if (bus.start) begin
                    res    <= sc_res;
                    zero_r <= sc_res == '0;
                    done_r <= 1'b1;
                    if (bus.aluCtr == 4'b1010) begin
                        hi_r <= bus.input1;
                        lo_r <= '1;
                    end
                end
            end else begin
                acc <= step_acc;
                quo <= step_quo;
                cnt <= cnt - CNT_W'(1);
                if (last) begin
                    hi_r   <= step_acc;
                    lo_r   <= step_quo;
                    res    <= step_quo;
                    zero_r <= step_quo == '0;
                    done_r <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: table-driven directed vectors plus hand sequences for the multi-cycle corners
module tb_iter_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    iter_alu_if #(.WIDTH(32)) bus ();

    iter_alu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t v[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.aluCtr = ctr;
        bus.input1 = a;
        bus.input2 = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.input1 = $urandom;
        bus.input2 = $urandom;
    endtask

    task automatic wait_done(output int edges, output int busy_n);
        edges = 0;
        busy_n = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " done"}, 32'(bus.done), 32'd0);
        chk({tag, " aluRes"}, bus.aluRes, 32'd0);
        chk({tag, " zero"}, 32'(bus.zero), 32'd1);
        chk({tag, " hi"}, bus.hi, 32'd0);
        chk({tag, " lo"}, bus.lo, 32'd0);
    endtask

    initial begin
        int e, bn, dn;
        v[0]  = '{4'b0010, 32'd7,        32'd5,        0,  32'd12,       1'b0, 32'd0, 32'd0};
        v[1]  = '{4'b0110, 32'h5,        32'h5,        0,  32'd0,        1'b1, 32'd0, 32'd0};
        v[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h1,        0,  32'd1,        1'b0, 32'd0, 32'd0};
        v[3]  = '{4'b1000, 32'hFFFFFFFF, 32'h1,        0,  32'd0,        1'b1, 32'd0, 32'd0};
        v[4]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 0,  32'h00F000F0, 1'b0, 32'd0, 32'd0};
        v[5]  = '{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 0,  32'hFFF0FFF0, 1'b0, 32'd0, 32'd0};
        v[6]  = '{4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 0,  32'hFF00FF00, 1'b0, 32'd0, 32'd0};
        v[7]  = '{4'b1100, 32'h0,        32'h0,        0,  32'hFFFFFFFF, 1'b0, 32'd0, 32'd0};
        v[8]  = '{4'b1111, 32'd3,        32'd4,        0,  32'd0,        1'b1, 32'd0, 32'd0};
        v[9]  = '{4'b1001, 32'hFFFFFFFF, 32'd2,        32, 32'hFFFFFFFE, 1'b0, 32'd1, 32'hFFFFFFFE};
        v[10] = '{4'b0010, 32'hFFFFFFFF, 32'd1,        0,  32'd0,        1'b1, 32'd1, 32'hFFFFFFFE};
        v[11] = '{4'b1010, 32'd100,      32'd7,        32, 32'd14,       1'b0, 32'd2, 32'd14};
        v[12] = '{4'b1010, 32'd9,        32'd0,        0,  32'hFFFFFFFF, 1'b0, 32'd9, 32'hFFFFFFFF};
        v[13] = '{4'b1001, 32'd12345,    32'd6789,     32, 32'd83810205, 1'b0, 32'd0, 32'd83810205};
        v[14] = '{4'b1010, 32'hFFFFFFFF, 32'd1,        32, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFF};
        v[15] = '{4'b0111, 32'd1,        32'hFFFFFFFF, 0,  32'd0,        1'b1, 32'd0, 32'hFFFFFFFF};
        v[16] = '{4'b1000, 32'd1,        32'hFFFFFFFF, 0,  32'd1,        1'b0, 32'd0, 32'hFFFFFFFF};

        bus.start = 1'b0;
        bus.aluCtr = 4'd0;
        bus.input1 = '0;
        bus.input2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            start_op(v[i].ctr, v[i].a, v[i].b);
            wait_done(e, bn);
            chk($sformatf("v%0d latency", i), 32'(e), 32'(v[i].lat));
            chk($sformatf("v%0d busy cycles", i), 32'(bn), 32'(v[i].lat));
            chk($sformatf("v%0d aluRes", i), bus.aluRes, v[i].res);
            chk($sformatf("v%0d zero", i), 32'(bus.zero), 32'(v[i].z));
            chk($sformatf("v%0d hi", i), bus.hi, v[i].hi);
            chk($sformatf("v%0d lo", i), bus.lo, v[i].lo);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done drop", i), 32'(bus.done), 32'd0);
        end

        start_op(4'b0010, 32'd1, 32'd2);
        bus.start = 1'b1;
        bus.aluCtr = 4'b0110;
        bus.input1 = 32'd10;
        bus.input2 = 32'd3;
        start_op(4'b0110, 32'd10, 32'd3);
        chk("b2b second done", 32'(bus.done), 32'd1);
        chk("b2b second res", bus.aluRes, 32'd7);
        @(posedge clk);
        #1;
        chk("b2b done drop", 32'(bus.done), 32'd0);

        start_op(4'b1001, 32'hFFFFFFFF, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("mid busy", 32'(bus.busy), 32'd1);
        start_op(4'b0010, 32'd1, 32'd1);
        wait_done(e, bn);
        chk("mid latency", 32'(e + 6), 32'd32);
        chk("mid hi", bus.hi, 32'd1);
        chk("mid lo", bus.lo, 32'hFFFFFFFE);
        chk("mid aluRes", bus.aluRes, 32'hFFFFFFFE);
        dn = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        chk("mid extra done", 32'(dn), 32'd0);

        start_op(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("abort");
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dn++;
        end
        chk("abort no done", 32'(dn), 32'd0);
        start_op(4'b0010, 32'd1, 32'd1);
        wait_done(e, bn);
        chk("post latency", 32'(e), 32'd0);
        chk("post aluRes", bus.aluRes, 32'd2);
        chk("post zero", 32'(bus.zero), 32'd0);
        chk("post hi", bus.hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
